// File: rtl/readout_capture.sv
// Write side of the readout DPRAM: captures an indexed packet stream into the DPRAM and tracks frame completion/timeout.
// Optional pre-capture zeroing sweep is built when READOUT_CAPTURE_CLEAR_EN is defined.
module readout_capture #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  captureStart,
  input  logic [ADDR_WIDTH:0]   expectedCount,
  input  logic [ADDR_WIDTH-1:0] packetIndex,
  input  logic [DATA_WIDTH-1:0] packetData,
  input  logic                  packetValid,
  output logic [ADDR_WIDTH-1:0] dpramAddress,
  output logic [DATA_WIDTH-1:0] dpramData,
  output logic                  dpramWrite,
  output logic                  readoutActive,
  output logic                  readoutValid,
  output logic                  timedOut,
  output logic                  overrun,
  output logic [ADDR_WIDTH:0]   receivedCount
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]    COUNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [ADDR_WIDTH:0]    latchedCount;
  logic [ADDR_WIDTH:0]    nextCount;
  logic                   captureComplete;
  logic                   timerExpired;

  // Count including a write accepted this cycle, so completion coincides with the final write.
  always_comb begin
    nextCount = receivedCount;
    if (packetValid && (receivedCount != COUNT_MAX)) begin
      nextCount = receivedCount + 1'b1;
    end
  end

  assign captureComplete = (latchedCount == '0) || (nextCount == latchedCount);
  assign timerExpired    = (timer == TIMER_LAST);

  // NOTE: all state and outputs are registered with non-blocking assignments so every
  // branch below reads the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      latchedCount  <= '0;
      dpramAddress  <= '0;
      dpramData     <= '0;
      dpramWrite    <= 1'b0;
      readoutActive <= 1'b0;
      readoutValid  <= 1'b0;
      timedOut      <= 1'b0;
      overrun       <= 1'b0;
      receivedCount <= '0;
    end else begin
      dpramWrite <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (packetValid) begin
            overrun <= 1'b1;
          end
          if (captureStart) begin
            latchedCount  <= expectedCount;
            readoutValid  <= 1'b0;
            timedOut      <= 1'b0;
            overrun       <= 1'b0;
            receivedCount <= '0;
            timer         <= '0;
            readoutActive <= 1'b1;
`ifdef READOUT_CAPTURE_CLEAR_EN
            state        <= CLEAR;
            dpramWrite   <= 1'b1;
            dpramAddress <= '0;
            dpramData    <= '0;
`else
            state <= CAPTURE;
`endif
          end
        end
`ifdef READOUT_CAPTURE_CLEAR_EN
        CLEAR: begin
          // The write address register doubles as the sweep counter.
          if (packetValid) begin
            overrun <= 1'b1;
          end
          if (&dpramAddress) begin
            state <= CAPTURE;
          end else begin
            dpramWrite   <= 1'b1;
            dpramAddress <= dpramAddress + 1'b1;
            dpramData    <= '0;
          end
        end
`endif
        CAPTURE: begin
          timer         <= timer + 1'b1;
          receivedCount <= nextCount;
          if (packetValid) begin
            dpramWrite   <= 1'b1;
            dpramAddress <= packetIndex;
            dpramData    <= packetData;
          end
          if (captureComplete) begin
            state         <= DONE;
            readoutValid  <= 1'b1;
            readoutActive <= 1'b0;
          end else if (timerExpired) begin
            state         <= DONE;
            timedOut      <= 1'b1;
            readoutActive <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readout_capture.sv
// Randomised scoreboard bench for readout_capture: expected DPRAM writes are queued by the driver and
// popped by an independent write monitor; frame status is checked against a simple frame model.
module tb_readout_capture;

  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int TIMEOUT = 100;
  localparam int DEPTH   = 1 << AW;
`ifdef READOUT_CAPTURE_CLEAR_EN
  localparam int CLEAR_CYCLES = DEPTH;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          captureStart;
  logic [AW:0]   expectedCount;
  logic [AW-1:0] packetIndex;
  logic [DW-1:0] packetData;
  logic          packetValid;
  logic [AW-1:0] dpramAddress;
  logic [DW-1:0] dpramData;
  logic          dpramWrite;
  logic          readoutActive;
  logic          readoutValid;
  logic          timedOut;
  logic          overrun;
  logic [AW:0]   receivedCount;

  readout_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .captureStart(captureStart), .expectedCount(expectedCount),
    .packetIndex(packetIndex), .packetData(packetData), .packetValid(packetValid),
    .dpramAddress(dpramAddress), .dpramData(dpramData), .dpramWrite(dpramWrite),
    .readoutActive(readoutActive), .readoutValid(readoutValid), .timedOut(timedOut),
    .overrun(overrun), .receivedCount(receivedCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t           expQ[$];
  logic [DW-1:0] modelMem[DEPTH];
  logic [DW-1:0] tbMem[DEPTH];
  int            cycle = 0;
  int            entry;
  int            assertions = 0;
  int            failures = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Behaves as the DPRAM the block feeds; read back at frame end.
  always @(posedge clk) if (dpramWrite === 1'b1) tbMem[dpramAddress] <= dpramData;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (dpramWrite === 1'b1) begin
      if (expQ.size() == 0) begin
        assertions++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h at cycle %0d, expected no write",
                 dpramAddress, dpramData, cycle);
      end else begin
        e = expQ.pop_front();
        check("write_addr", 64'(dpramAddress), 64'(e.addr));
        check("write_data", 64'(dpramData), 64'(e.data));
        check("write_cycle", 64'(cycle), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    packetValid = 1'b1;
    packetIndex = idx;
    packetData  = data;
    expQ.push_back('{addr: idx, data: data, cyc: cycle + 1});
    modelMem[idx] = data;
    step();
    packetValid = 1'b0;
  endtask

  task automatic drop(input int n);
    for (int i = 0; i < n; i++) begin
      packetValid = 1'b1;
      packetIndex = AW'($urandom);
      packetData  = $urandom;
      step();
    end
    packetValid = 1'b0;
  endtask

  task automatic start_frame(input int count, input bit noise);
    captureStart  = 1'b1;
    expectedCount = (AW + 1)'(count);
    if (CLEAR_CYCLES > 0) begin
      for (int i = 0; i < DEPTH; i++) begin
        expQ.push_back('{addr: AW'(i), data: '0, cyc: cycle + 1 + i});
        modelMem[i] = '0;
      end
    end
    step();
    captureStart = 1'b0;
    for (int i = 0; i < CLEAR_CYCLES; i++) begin
      packetValid = noise;
      packetIndex = AW'($urandom);
      packetData  = $urandom;
      step();
    end
    packetValid = 1'b0;
    entry = cycle;
  endtask

  task automatic wait_done(input string name, output int doneCycle);
    doneCycle = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (readoutActive === 1'b0) begin
        doneCycle = cycle;
        break;
      end
    end
    if (doneCycle < 0) begin
      assertions++;
      failures++;
      $display("FAIL %s: got no frame end within 2000 cycles, expected readoutActive to fall", name);
    end
    step();
  endtask

  task automatic readback(input string name);
    int bad = 0;
    step();
    for (int i = 0; i < DEPTH; i++) if (tbMem[i] !== modelMem[i]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic check_end(input string name, input bit valid, input bit tout, input int count);
    check({name, "_valid"}, 64'(readoutValid), 64'(valid));
    check({name, "_timedout"}, 64'(timedOut), 64'(tout));
    check({name, "_active"}, 64'(readoutActive), 64'd0);
    check({name, "_count"}, 64'(receivedCount), 64'(count));
  endtask

  initial begin
    int doneCycle;
    int n;
    logic [DW-1:0] prior;

    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i] = '0;
      tbMem[i]    = '0;
    end
    reset = 1'b1; captureStart = 1'b0; expectedCount = '0;
    packetIndex = '0; packetData = '0; packetValid = 1'b0;
    repeat (3) step();
    check("reset_outputs", 64'({dpramAddress, dpramData, dpramWrite, readoutActive, readoutValid,
                                timedOut, overrun, receivedCount}), 64'd0);
    check("reset_state", 64'(dut.state), 64'd0);
    reset = 1'b0;
    step();

    // Packets in IDLE are dropped and flag overrun.
    drop(2);
    check("overrun_idle", 64'(overrun), 64'd1);

    // Full frame of 64 back-to-back words.
    start_frame(64, 1'b0);
    check("start_active", 64'(readoutActive), 64'd1);
    check("start_overrun_cleared", 64'(overrun), 64'd0);
    for (int i = 0; i < 64; i++) send(AW'(32 + i), DW'(32'h0820 + i));
    check_end("full_frame", 1'b1, 1'b0, 64);
    readback("full_frame_readback");

    // Packets in DONE are dropped, status held.
    drop(3);
    check("overrun_done", 64'(overrun), 64'd1);
    check("done_hold_valid", 64'(readoutValid), 64'd1);

    // Partial refill of the same window: upper half reads 0 only when the clear sweep exists.
    prior = modelMem[9'h50];
    start_frame(32, 1'b1);
    check("overrun_clear", 64'(overrun), 64'(CLEAR_CYCLES > 0));
    for (int i = 0; i < 32; i++) send(AW'(32 + i), $urandom);
    check_end("clear_frame", 1'b1, 1'b0, 32);
    readback("clear_frame_readback");
    check("clear_upper_word", 64'(tbMem[9'h50]), (CLEAR_CYCLES > 0) ? 64'd0 : 64'(prior));

    // Timeout: 10 of 64 words.
    start_frame(64, 1'b0);
    for (int i = 0; i < 10; i++) send(AW'($urandom), $urandom);
    wait_done("timeout_wait", doneCycle);
    check("timeout_exit_cycle", 64'(doneCycle), 64'(entry + TIMEOUT));
    check_end("timeout", 1'b0, 1'b1, 10);

    // Zero-length frame completes on its first CAPTURE cycle.
    start_frame(0, 1'b0);
    step();
    check_end("zero_count", 1'b1, 1'b0, 0);

    // captureStart during CAPTURE is ignored.
    start_frame(8, 1'b0);
    for (int i = 0; i < 3; i++) send(AW'($urandom), $urandom);
    captureStart = 1'b1;
    expectedCount = 10'd2;
    step();
    captureStart = 1'b0;
    check("start_ignored_active", 64'(readoutActive), 64'd1);
    for (int i = 0; i < 5; i++) send(AW'($urandom), $urandom);
    check_end("start_ignored", 1'b1, 1'b0, 8);

    // Final word lands on the timeout cycle: completion wins.
    start_frame(2, 1'b0);
    send(AW'($urandom), $urandom);
    while (cycle < entry + TIMEOUT - 1) step();
    send(AW'($urandom), $urandom);
    check("race_exit_cycle", 64'(cycle), 64'(entry + TIMEOUT));
    check_end("race", 1'b1, 1'b0, 2);

    // Random frames with duplicate-prone indices and random gaps.
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 30);
      start_frame(n, 1'b0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) step();
        send(AW'($urandom_range(0, 63)), $urandom);
      end
      check_end("random_frame", 1'b1, 1'b0, n);
      readback("random_readback");
    end

    // Reset mid-CAPTURE discards the in-flight packet.
    start_frame(20, 1'b0);
    for (int i = 0; i < 5; i++) send(AW'($urandom), $urandom);
    packetValid = 1'b1;
    packetIndex = AW'($urandom);
    packetData  = $urandom;
    reset = 1'b1;
    step();
    packetValid = 1'b0;
    check("midreset_outputs", 64'({dpramAddress, dpramData, dpramWrite, readoutActive, readoutValid,
                                   timedOut, overrun, receivedCount}), 64'd0);
    check("midreset_state", 64'(dut.state), 64'd0);
    reset = 1'b0;
    repeat (3) step();

    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
